// File: rtl/soc_bb_ext_memory_pkg.sv
// soc_bb_ext_memory_pkg: status register offsets, region type and the address decode helper
package soc_bb_ext_memory_pkg;
  localparam int RD_CNT_OFF = 0;
  localparam int WR_CNT_OFF = 1;
  localparam int ERR_CNT_OFF = 2;
  localparam int LAST_ERR_OFF = 3;
  localparam int STATUS_WORDS = 4;
  typedef enum logic [1:0] {REG_SRAM, REG_STATUS, REG_OOR} region_t;
  function automatic region_t decode_region(input logic [63:0] addr, input logic [63:0] base,
                                            input int unsigned words, input int unsigned shift);
    logic [63:0] w;
    w = (addr - base) >> shift;
    return addr < base ? REG_OOR : w < 64'(words) ? REG_SRAM :
           w < 64'(words + STATUS_WORDS) ? REG_STATUS : REG_OOR;
  endfunction
endpackage

// File: rtl/soc_bb_ext_rdpipe.sv
// soc_bb_ext_rdpipe: DEPTH-stage read data delay line with valid bits and sync flush (i_v/i_d in, o_v/o_d out)
module soc_bb_ext_rdpipe #(
  parameter int DW = 32,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_v,
  input  logic [DW-1:0] i_d,
  output logic          o_v,
  output logic [DW-1:0] o_d
);
  logic [DEPTH-1:0] r_v;
  logic [DW-1:0] r_d [DEPTH];
  always_ff @(posedge clk) begin
    r_v <= rst ? '0 : DEPTH'({r_v, i_v});
    r_d[0] <= i_d;
    for (int i = 1; i < DEPTH; i++) r_d[i] <= r_d[i-1];
  end
  assign o_v = r_v[DEPTH-1];
  assign o_d = r_d[DEPTH-1];
endmodule

// File: rtl/soc_bb_ext_memory.sv
// soc_bb_ext_memory: Blackbone ext-bus responder (bb_ext_* addr/din/en/we in, dout/err_o out) with SRAM, status window, LATENCY-cycle reads
module soc_bb_ext_memory
  import soc_bb_ext_memory_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            MEM_WORDS = 1024,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            LATENCY   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] bb_ext_addr_i,
  input  logic [DW-1:0] bb_ext_din_i,
  input  logic          bb_ext_en_i,
  input  logic          bb_ext_we_i,
  output logic [DW-1:0] bb_ext_dout_o,
  output logic          err_o
);
  localparam int SH = $clog2(DW / 8);
  localparam int MW = $clog2(MEM_WORDS);
  logic [AW-1:0] w_off;
  logic [MW-1:0] w_idx;
  logic [1:0] w_soff;
  region_t w_reg;
  logic w_rv, w_rd, w_wr, w_swr, w_oor, w_pv;
  logic [DW-1:0] w_stat, w_rdata, w_pd;
  logic [DW-1:0] r_mem [MEM_WORDS];
  logic [DW-1:0] r_rd_cnt, r_wr_cnt, r_err_cnt, r_last_err;
  function automatic logic [DW-1:0] sat(input logic [DW-1:0] v);
    return &v ? v : v + DW'(1);
  endfunction
  assign w_off = bb_ext_addr_i - BASE_ADDR;
  assign w_idx = MW'(w_off >> SH);
  assign w_soff = 2'(w_off >> SH);
  assign w_reg = decode_region(64'(bb_ext_addr_i), 64'(BASE_ADDR), MEM_WORDS, SH);
  assign w_rv = bb_ext_en_i & ~bb_ext_we_i;
  assign w_rd = w_rv & (w_reg != REG_OOR);
  assign w_wr = bb_ext_en_i & bb_ext_we_i & (w_reg == REG_SRAM);
  assign w_swr = bb_ext_en_i & bb_ext_we_i & (w_reg == REG_STATUS);
  assign w_oor = bb_ext_en_i & (w_reg == REG_OOR);
  assign w_stat = w_soff == 2'(RD_CNT_OFF) ? r_rd_cnt :
                  w_soff == 2'(WR_CNT_OFF) ? r_wr_cnt :
                  w_soff == 2'(ERR_CNT_OFF) ? r_err_cnt :
                  w_soff == 2'(LAST_ERR_OFF) ? r_last_err : '0;
  assign w_rdata = w_reg == REG_SRAM ? r_mem[w_idx] : w_reg == REG_STATUS ? w_stat : '0;
  if (LATENCY > 1) begin : g_pipe
    soc_bb_ext_rdpipe #(.DW(DW), .DEPTH(LATENCY - 1)) u_pipe (
      .clk(clk), .rst(rst), .i_v(w_rv), .i_d(w_rdata), .o_v(w_pv), .o_d(w_pd)
    );
  end else begin : g_direct
    assign w_pv = w_rv;
    assign w_pd = w_rdata;
  end
  always_ff @(posedge clk) begin
    r_rd_cnt <= rst || (w_swr && w_soff == 2'(RD_CNT_OFF)) ? '0 : w_rd ? sat(r_rd_cnt) : r_rd_cnt;
    r_wr_cnt <= rst || (w_swr && w_soff == 2'(WR_CNT_OFF)) ? '0 : w_wr ? sat(r_wr_cnt) : r_wr_cnt;
    r_err_cnt <= rst || (w_swr && w_soff == 2'(ERR_CNT_OFF)) ? '0 : w_oor ? sat(r_err_cnt) : r_err_cnt;
    r_last_err <= rst ? '0 : w_oor ? DW'(bb_ext_addr_i) : r_last_err;
    err_o <= ~rst & w_oor;
    bb_ext_dout_o <= rst ? '0 : w_pv ? w_pd : bb_ext_dout_o;
  end
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[w_idx] <= bb_ext_din_i;
  end
endmodule

// File: tb/tb_soc_bb_ext_memory.sv
// tb_soc_bb_ext_memory: directed self-checking bench for soc_bb_ext_memory
module tb_soc_bb_ext_memory;
  localparam int LAT = 3;
  localparam logic [31:0] B = 32'h1000_0000;
  localparam logic [31:0] S_RD = B + 32'h1000;
  localparam logic [31:0] S_WR = B + 32'h1004;
  localparam logic [31:0] S_ERR = B + 32'h1008;
  localparam logic [31:0] S_LAST = B + 32'h100C;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, we = 1'b0, err;
  logic [31:0] addr = '0, din = '0, dout;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  soc_bb_ext_memory #(.AW(32), .DW(32), .MEM_WORDS(1024), .BASE_ADDR(B), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bb_ext_addr_i(addr), .bb_ext_din_i(din),
    .bb_ext_en_i(en), .bb_ext_we_i(we), .bb_ext_dout_o(dout), .err_o(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e;
    we = w;
    addr = a;
    din = d;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    put(1'b1, 1'b0, a, '0);
    put(1'b0, 1'b0, '0, '0);
    repeat (LAT - 1) @(negedge clk);
    chk(tag, dout, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] e;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, '0);
    chk("rst_err", 32'(err), '0);
    rst = 1'b0;
    put(1'b1, 1'b1, B + 32'h10, 32'hCAFE_F00D);
    rd("raw", B + 32'h10, 32'hCAFE_F00D);
    rd("rd_cnt1", S_RD, 32'd1);
    rd("wr_cnt1", S_WR, 32'd1);
    rd("subword", B + 32'h13, 32'hCAFE_F00D);
    for (int i = 0; i < 8; i++) put(1'b1, 1'b1, B + 32'(4 * i), 32'(i));
    for (int c = 0; c < 9 + LAT; c++) begin
      @(negedge clk);
      e = c < LAT ? 32'hCAFE_F00D : 32'(c - LAT > 7 ? 7 : c - LAT);
      if (c >= LAT - 1) chk("stream", dout, e);
      en = c < 8;
      we = 1'b0;
      addr = B + 32'(4 * c);
    end
    rd("wr_cnt9", S_WR, 32'd9);
    put(1'b1, 1'b0, B + 32'h2000, '0);
    put(1'b0, 1'b0, '0, '0);
    chk("oor_err_hi", 32'(err), 32'd1);
    @(negedge clk);
    chk("oor_err_lo", 32'(err), 32'd0);
    repeat (LAT - 2) @(negedge clk);
    chk("oor_dout", dout, '0);
    rd("err_cnt1", S_ERR, 32'd1);
    rd("last_err1", S_LAST, B + 32'h2000);
    put(1'b1, 1'b1, B - 32'd4, 32'h1234);
    put(1'b0, 1'b0, '0, '0);
    chk("below_base_err", 32'(err), 32'd1);
    rd("err_cnt2", S_ERR, 32'd2);
    rd("last_err2", S_LAST, B - 32'd4);
    put(1'b1, 1'b1, S_LAST, '0);
    rd("last_ro", S_LAST, B - 32'd4);
    put(1'b1, 1'b0, B + 32'h1010, '0);
    put(1'b0, 1'b0, '0, '0);
    chk("status_end_err", 32'(err), 32'd1);
    put(1'b1, 1'b0, B, '0);
    put(1'b1, 1'b1, S_RD, '0);
    rd("clr_rd", S_RD, 32'd0);
    rd("clr_rd_after", S_RD, 32'd1);
    put(1'b1, 1'b1, S_WR, '0);
    rd("clr_wr", S_WR, 32'd0);
    put(1'b1, 1'b1, B + 32'h14, 32'h5555_AAAA);
    put(1'b1, 1'b1, B + 32'h14, 32'hDEAD_BEEF);
    rst = 1'b1;
    put(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    rd("rst_wr_blocked", B + 32'h14, 32'h5555_AAAA);
    put(1'b1, 1'b0, B + 32'h14, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      chk("flush", dout, '0);
      @(negedge clk);
    end
    rd("rst_rd_cnt", S_RD, 32'd0);
    rd("rst_wr_cnt", S_WR, 32'd0);
    rd("rst_err_cnt", S_ERR, 32'd0);
    @(negedge clk);
    force dut.r_err_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_err_cnt;
    put(1'b1, 1'b0, B + 32'h2000, '0);
    rd("sat1", S_ERR, 32'hFFFF_FFFF);
    put(1'b1, 1'b0, B + 32'h2000, '0);
    put(1'b1, 1'b1, B + 32'h3000, '0);
    rd("sat2", S_ERR, 32'hFFFF_FFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
